arbitro_rr: RTL and testbench

Round-robin arbiter and router between the four input virtual-channel FIFOs (F0..F3) and the four output port FIFOs (P4..P7). Each cycle it pops at most one word from an eligible input FIFO and pushes it, one cycle later, into the output FIFO selected by the word's destination field. It generates the `pop_F0..pop_F3` strobes and the `IDLE` indication that the downstream pop counter samples. It also honours per-port almost-full backpressure.

---
 rtl/arbitro_rr.sv | 147 ++++++++++++++
 tb/tb_arbitro_rr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr.sv
// Purpose : round-robin arbiter/router from four input VC FIFOs (F0..F3) to four output port FIFOs (P4..P7).
// Latency : pop strobe is combinational in cycle N; push strobe and data_out are registered, valid in cycle N+1.
// Backpressure: an input whose destination port is almost-full is skipped that cycle; other inputs are still served.
//
// Ports:
//   clk, reset                      - rising-edge clock, asynchronous active-high reset
//   data_in_F0..F3, empty_F0..F3    - first-word-fall-through heads of the input FIFOs and their empty flags
//   almost_full_P4..P7              - per-output-port almost-full flags
//   pop_F0..F3                      - combinational pop strobes (one-hot or zero)
//   push_P4..P7, data_out           - registered push strobes (one-hot or zero) and the word being pushed
//   IDLE                            - registered, high while the arbiter sits in its IDLE state
module arbitro_rr #(
    parameter int data_width = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] data_in_F0,
    input  logic [data_width-1:0] data_in_F1,
    input  logic [data_width-1:0] data_in_F2,
    input  logic [data_width-1:0] data_in_F3,
    input  logic                  empty_F0,
    input  logic                  empty_F1,
    input  logic                  empty_F2,
    input  logic                  empty_F3,
    input  logic                  almost_full_P4,
    input  logic                  almost_full_P5,
    input  logic                  almost_full_P6,
    input  logic                  almost_full_P7,
    output logic                  pop_F0,
    output logic                  pop_F1,
    output logic                  pop_F2,
    output logic                  pop_F3,
    output logic                  push_P4,
    output logic                  push_P5,
    output logic                  push_P6,
    output logic                  push_P7,
    output logic [data_width-1:0] data_out,
    output logic                  IDLE
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            rr_q;
    logic [3:0]            push_q;
    logic [data_width-1:0] data_q;
    logic                  idle_q;

    logic [data_width-1:0] din [4];
    logic [3:0]            empty;
    logic [3:0]            afull;
    logic [3:0]            elig;

    assign din[0] = data_in_F0;
    assign din[1] = data_in_F1;
    assign din[2] = data_in_F2;
    assign din[3] = data_in_F3;
    assign empty  = {empty_F3, empty_F2, empty_F1, empty_F0};
    assign afull  = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};

    // An input is eligible when it holds a word and that word's destination can accept it.
    for (genvar k = 0; k < 4; k++) begin : g_elig
        logic [1:0] dest;
        assign dest    = din[k][data_width-1 -: 2];
        assign elig[k] = ~empty[k] & ~afull[dest];
    end

    // Search rr, rr+1, rr+2, rr+3. Scanning offsets from high to low lets the
    // smallest offset (closest to rr) overwrite the result last and win.
    logic       any_elig;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    always_comb begin
        any_elig = 1'b0;
        gnt_idx  = rr_q;
        cand     = rr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_q + 2'(i);
            if (elig[cand]) begin
                any_elig = 1'b1;
                gnt_idx  = cand;
            end
        end
    end

    // No grants while reset is held or before the first post-reset clock.
    logic                  grant;
    logic [3:0]            pop_vec;
    logic [data_width-1:0] sel_word;
    logic [1:0]            sel_dest;

    assign grant    = any_elig & ~reset & (state_q != ST_INIT);
    assign pop_vec  = grant ? (4'b0001 << gnt_idx) : 4'b0000;
    assign sel_word = din[gnt_idx];
    assign sel_dest = sel_word[data_width-1 -: 2];

    assign {pop_F3, pop_F2, pop_F1, pop_F0} = pop_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            rr_q    <= 2'd0;
            push_q  <= 4'b0000;
            data_q  <= '0;
            idle_q  <= 1'b0;
        end else begin
            push_q <= 4'b0000;
            if (grant) begin
                rr_q   <= gnt_idx + 2'd1;
                push_q <= 4'b0001 << sel_dest;
                data_q <= sel_word;
            end
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_IDLE;
                    idle_q  <= 1'b1;
                end
                ST_IDLE: begin
                    if (grant) begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // No grant now means nothing will be pushed next cycle either.
                    if ((&empty) && !grant) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {push_P7, push_P6, push_P5, push_P4} = push_q;
    assign data_out = data_q;
    assign IDLE     = idle_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Purpose : self-checking bench for arbitro_rr with queue-backed input FIFOs and a push scoreboard.
// Latency : expected pushes are tagged with the cycle they must appear in (pop cycle + 1).
// Backpressure: almost-full flags are forced for directed cases and randomised in the soak phase.
module tb_arbitro_rr;

    localparam int DW    = 10;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in_F0, data_in_F1, data_in_F2, data_in_F3;
    logic          empty_F0, empty_F1, empty_F2, empty_F3;
    logic          almost_full_P4, almost_full_P5, almost_full_P6, almost_full_P7;
    logic          pop_F0, pop_F1, pop_F2, pop_F3;
    logic          push_P4, push_P5, push_P6, push_P7;
    logic [DW-1:0] data_out;
    logic          IDLE;

    always #5 clk = ~clk;

    arbitro_rr #(.data_width(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_F0     (data_in_F0),
        .data_in_F1     (data_in_F1),
        .data_in_F2     (data_in_F2),
        .data_in_F3     (data_in_F3),
        .empty_F0       (empty_F0),
        .empty_F1       (empty_F1),
        .empty_F2       (empty_F2),
        .empty_F3       (empty_F3),
        .almost_full_P4 (almost_full_P4),
        .almost_full_P5 (almost_full_P5),
        .almost_full_P6 (almost_full_P6),
        .almost_full_P7 (almost_full_P7),
        .pop_F0         (pop_F0),
        .pop_F1         (pop_F1),
        .pop_F2         (pop_F2),
        .pop_F3         (pop_F3),
        .push_P4        (push_P4),
        .push_P5        (push_P5),
        .push_P6        (push_P6),
        .push_P7        (push_P7),
        .data_out       (data_out),
        .IDLE           (IDLE)
    );

    typedef enum int {M_INIT, M_IDLE, M_ACTIVE} mstate_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [1:0]    port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fmem [4][DEPTH];
    int            fhead [4];
    int            fcnt  [4];
    int            m_rr;
    mstate_t       m_state;
    logic [DW-1:0] last_data = '0;
    logic [3:0]    af_force;
    bit            af_rand;
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    exp_t          mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] head(input int k);
        return fmem[k][fhead[k]];
    endfunction

    task automatic load(input int k, input logic [DW-1:0] w);
        if (fcnt[k] < DEPTH) begin
            fmem[k][(fhead[k] + fcnt[k]) % DEPTH] = w;
            fcnt[k]++;
        end
    endtask

    task automatic drive_inputs();
        logic [3:0] af;
        af = af_force;
        if (af_rand) af = af | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
        {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4} = af;
        empty_F0   = (fcnt[0] == 0);
        empty_F1   = (fcnt[1] == 0);
        empty_F2   = (fcnt[2] == 0);
        empty_F3   = (fcnt[3] == 0);
        // Junk on empty inputs must never be granted.
        data_in_F0 = (fcnt[0] != 0) ? head(0) : DW'($urandom);
        data_in_F1 = (fcnt[1] != 0) ? head(1) : DW'($urandom);
        data_in_F2 = (fcnt[2] != 0) ? head(2) : DW'($urandom);
        data_in_F3 = (fcnt[3] != 0) ? head(3) : DW'($urandom);
    endtask

    task automatic apply_reset(input bit r);
        if (r && !reset) begin
            reset = 1'b1;
            #1;
            chk("rst_push", {28'd0, push_P7, push_P6, push_P5, push_P4}, 32'd0);
            chk("rst_data_out", {22'd0, data_out}, 32'd0);
            chk("rst_IDLE", {31'd0, IDLE}, 32'd0);
            sb.delete();
            m_rr      = 0;
            m_state   = M_INIT;
            last_data = '0;
        end else begin
            reset = r;
            #1;
        end
    endtask

    // Reference: scan the four queues in round-robin order from m_rr.
    task automatic evaluate();
        int            g;
        bit            all_empty;
        logic [3:0]    exp_pop;
        logic [3:0]    af_now;
        logic [DW-1:0] w;
        exp_t          e;
        g         = -1;
        all_empty = 1'b1;
        exp_pop   = 4'd0;
        af_now    = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};
        for (int i = 0; i < 4; i++) if (fcnt[i] != 0) all_empty = 1'b0;
        if (!reset && m_state != M_INIT) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_rr + i) % 4;
                w = head(k);
                if (g < 0 && fcnt[k] > 0 && !af_now[w[DW-1 -: 2]]) g = k;
            end
        end
        if (g >= 0) exp_pop[g] = 1'b1;
        chk("pop", {28'd0, pop_F3, pop_F2, pop_F1, pop_F0}, {28'd0, exp_pop});
        chk("IDLE", {31'd0, IDLE}, {31'd0, (m_state == M_IDLE)});
        if (g >= 0) begin
            w      = head(g);
            e.cyc  = 32'(cyc + 1);
            e.port = w[DW-1 -: 2];
            e.data = w;
            sb.push_back(e);
            fhead[g] = (fhead[g] + 1) % DEPTH;
            fcnt[g]--;
            m_rr = (g + 1) % 4;
        end
        if (reset) m_state = M_INIT;
        else begin
            case (m_state)
                M_INIT:   m_state = M_IDLE;
                M_IDLE:   if (g >= 0) m_state = M_ACTIVE;
                default:  if (all_empty && g < 0) m_state = M_IDLE;
            endcase
        end
    endtask

    // One clock cycle; entered just after a rising edge. A late reset lands after the grant decision.
    task automatic step(input bit r, input bit late);
        #1;
        drive_inputs();
        if (!late) apply_reset(r);
        else #1;
        #1;
        evaluate();
        if (late) begin
            #3;
            apply_reset(r);
        end
        @(posedge clk);
    endtask

    // Monitor: every output push must match the oldest expectation, in its expected cycle.
    always @(negedge clk) begin
        if ({push_P7, push_P6, push_P5, push_P4} != 4'd0) begin
            if (sb.size() == 0) begin
                chk("push_unexpected", {28'd0, push_P7, push_P6, push_P5, push_P4}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("push_vec", {28'd0, push_P7, push_P6, push_P5, push_P4}, 32'd1 << mon_e.port);
                chk("push_data", {22'd0, data_out}, {22'd0, mon_e.data});
                chk("push_cycle", cyc, mon_e.cyc);
                last_data = mon_e.data;
            end
        end else begin
            if (sb.size() > 0 && sb[0].cyc <= 32'(cyc)) begin
                mon_e = sb.pop_front();
                chk("push_missing", {28'd0, push_P7, push_P6, push_P5, push_P4}, 32'd1 << mon_e.port);
            end
            chk("data_out_hold", {22'd0, data_out}, {22'd0, last_data});
        end
    end

    initial begin
        reset = 1'b1;
        af_force = 4'd0;
        af_rand  = 1'b0;
        m_rr     = 0;
        m_state  = M_INIT;
        for (int k = 0; k < 4; k++) begin
            fhead[k] = 0;
            fcnt[k]  = 0;
        end
        drive_inputs();
        #2;
        chk("init_push", {28'd0, push_P7, push_P6, push_P5, push_P4}, 32'd0);
        chk("init_data_out", {22'd0, data_out}, 32'd0);
        chk("init_IDLE", {31'd0, IDLE}, 32'd0);
        @(posedge clk);

        // Reset release: one INIT cycle, then IDLE.
        step(1, 0);
        step(1, 0);
        repeat (4) step(0, 0);

        // Single word F2 -> P6.
        load(2, 10'h2A5);
        repeat (4) step(0, 0);

        // Fairness: three words of destination 0 in every FIFO.
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) load(k, {2'd0, 8'(r * 16 + k)});
        repeat (15) step(0, 0);

        // Backpressure: F0 -> P5 blocked, F1 -> P7 served, then F0 once released.
        load(0, {2'd1, 8'h11});
        load(1, {2'd3, 8'h33});
        af_force = 4'b0010;
        step(0, 0);
        af_force = 4'b0000;
        repeat (3) step(0, 0);

        // Wrap: F3 alone, then rr must sit at 0 while nothing is eligible.
        load(3, {2'd2, 8'h77});
        repeat (4) step(0, 0);
        load(1, {2'd1, 8'h41});
        load(0, {2'd0, 8'h40});
        repeat (4) step(0, 0);

        // Mid-cycle reset while idle.
        step(1, 0);
        step(0, 0);
        repeat (2) step(0, 0);

        // Reset arriving after a pop: the word must not be pushed and rr returns to 0.
        load(1, {2'd1, 8'h5C});
        step(1, 1);
        step(1, 0);
        step(0, 0);
        load(3, {2'd3, 8'h63});
        load(0, {2'd2, 8'h60});
        repeat (4) step(0, 0);

        // Random soak with random backpressure and occasional resets.
        af_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0 && fcnt[k] < DEPTH - 4) load(k, DW'($urandom));
            if ($urandom_range(0, 149) == 0) begin
                step(1, 1'($urandom_range(0, 1)));
                step(1, 0);
                step(0, 0);
            end else begin
                step(0, 0);
            end
        end
        af_rand = 1'b0;
        repeat (60) step(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
